// File: rtl/ca_ram_sched_pkg.sv
// Shared types and screen constants for the cellular-automaton RAM scheduler.
package ca_ram_sched_pkg;

   localparam int unsigned RAM_ADDR_W  = 10;
   localparam int unsigned RAM_DATA_W  = 16;
   localparam int unsigned XY_W        = 11;
   localparam int unsigned SCR_START_X = 1296;
   localparam int unsigned SCR_LAST_Y  = 1023;
   localparam int unsigned JOB_TIMEOUT = 511;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_GEN  = 2'd1,
      ST_INIT = 2'd2
   } state_t;

endpackage

// File: rtl/ca_ram_sched_ram_port_mux.sv
// Combinational RAM port steering: display-first read port A, owner-only write port B.
module ca_ram_sched_ram_port_mux
   import ca_ram_sched_pkg::*;
#(
   parameter int unsigned ADDR_W = RAM_ADDR_W,
   parameter int unsigned DATA_W = RAM_DATA_W
) (
   input  logic              rst,
   input  state_t            state,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   input  logic              gen_rreq,
   input  logic [ADDR_W-1:0] gen_raddr,
   input  logic              gen_wreq,
   input  logic [ADDR_W-1:0] gen_waddr,
   input  logic [DATA_W-1:0] gen_wdata,
   input  logic              init_wreq,
   input  logic [ADDR_W-1:0] init_waddr,
   input  logic [DATA_W-1:0] init_wdata,
   output logic              gen_rgnt_c,
   output logic              ena_c,
   output logic [ADDR_W-1:0] addra_c,
   output logic              enb_c,
   output logic [ADDR_W-1:0] addrb_c,
   output logic [DATA_W-1:0] dinb_c
);

   // Display is never stalled; the generator only reads while it owns the job.
   assign gen_rgnt_c = gen_rreq & ~disp_req & (state == ST_GEN) & ~rst;
   assign ena_c      = (disp_req | gen_rgnt_c) & ~rst;
   assign addra_c    = disp_req ? disp_addr : gen_raddr;

   always_comb begin
      enb_c   = 1'b0;
      addrb_c = '0;
      dinb_c  = '0;
      if (!rst) begin
         if (state == ST_GEN && gen_wreq) begin
            enb_c   = 1'b1;
            addrb_c = gen_waddr;
            dinb_c  = gen_wdata;
         end else if (state == ST_INIT && init_wreq) begin
            enb_c   = 1'b1;
            addrb_c = init_waddr;
            dinb_c  = init_wdata;
         end
      end
   end

endmodule

// File: rtl/ca_ram_sched.sv
// Per-scan-line job scheduler (generator or init pass) and image RAM port arbiter.
module ca_ram_sched
   import ca_ram_sched_pkg::*;
#(
   parameter int unsigned ADDR_W  = RAM_ADDR_W,
   parameter int unsigned DATA_W  = RAM_DATA_W,
   parameter int unsigned START_X = SCR_START_X,
   parameter int unsigned LAST_Y  = SCR_LAST_Y,
   parameter int unsigned TIMEOUT = JOB_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [XY_W-1:0]   counter_x,
   input  logic [XY_W-1:0]   counter_y,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic              gen_start,
   input  logic              gen_rreq,
   input  logic [ADDR_W-1:0] gen_raddr,
   output logic              gen_rgnt,
   output logic              gen_rvalid,
   input  logic              gen_wreq,
   input  logic [ADDR_W-1:0] gen_waddr,
   input  logic [DATA_W-1:0] gen_wdata,
   input  logic              gen_done,
   output logic              init_start,
   input  logic              init_wreq,
   input  logic [ADDR_W-1:0] init_waddr,
   input  logic [DATA_W-1:0] init_wdata,
   input  logic              init_done,
   output logic              ram_ena,
   output logic [ADDR_W-1:0] ram_addra,
   output logic              ram_enb,
   output logic [ADDR_W-1:0] ram_addrb,
   output logic [DATA_W-1:0] ram_dinb,
   output logic              busy,
   output logic              overrun,
   output logic              timeout
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   job_cnt;
   logic               launch_c, expire_c, slot_free_c;
   logic               gen_start_nxt, init_start_nxt, set_overrun, set_timeout;
   logic               gen_rgnt_c;

   assign launch_c = (counter_x == XY_W'(START_X));
   assign expire_c = (state != ST_IDLE) && (job_cnt == CNT_W'(TIMEOUT - 1));
   assign busy     = (state != ST_IDLE);
   assign gen_rgnt = gen_rgnt_c;

   // Next state: a done pulse in the launch cycle frees the slot for the new job.
   always_comb begin
      state_nxt      = state;
      slot_free_c    = 1'b0;
      gen_start_nxt  = 1'b0;
      init_start_nxt = 1'b0;
      set_overrun    = 1'b0;
      set_timeout    = 1'b0;
      case (state)
         ST_IDLE: slot_free_c = 1'b1;
         ST_GEN: begin
            if (gen_done) begin
               state_nxt   = ST_IDLE;
               slot_free_c = 1'b1;
            end else if (expire_c) begin
               state_nxt   = ST_IDLE;
               set_timeout = 1'b1;
            end
         end
         ST_INIT: begin
            if (init_done) begin
               state_nxt   = ST_IDLE;
               slot_free_c = 1'b1;
            end else if (expire_c) begin
               state_nxt   = ST_IDLE;
               set_timeout = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (launch_c) begin
         if (!slot_free_c) begin
            set_overrun = 1'b1;
         end else if (counter_y < XY_W'(LAST_Y)) begin
            gen_start_nxt = 1'b1;
            state_nxt     = ST_GEN;
         end else if (counter_y == XY_W'(LAST_Y)) begin
            init_start_nxt = 1'b1;
            state_nxt      = ST_INIT;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         gen_start  <= 1'b0;
         init_start <= 1'b0;
         gen_rvalid <= 1'b0;
         overrun    <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         state      <= state_nxt;
         gen_start  <= gen_start_nxt;
         init_start <= init_start_nxt;
         gen_rvalid <= gen_rgnt_c;
         overrun    <= overrun | set_overrun;
         timeout    <= timeout | set_timeout;
      end
   end

   // Job age counter, saturating at the top of its range.
   always_ff @(posedge clk) begin
      if (rst) begin
         job_cnt <= '0;
      end else if (gen_start_nxt || init_start_nxt) begin
         job_cnt <= '0;
      end else if (state != ST_IDLE && job_cnt != '1) begin
         job_cnt <= job_cnt + CNT_W'(1);
      end
   end

   ca_ram_sched_ram_port_mux #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_port_mux (
      .rst        (rst),
      .state      (state),
      .disp_req   (disp_req),
      .disp_addr  (disp_addr),
      .gen_rreq   (gen_rreq),
      .gen_raddr  (gen_raddr),
      .gen_wreq   (gen_wreq),
      .gen_waddr  (gen_waddr),
      .gen_wdata  (gen_wdata),
      .init_wreq  (init_wreq),
      .init_waddr (init_waddr),
      .init_wdata (init_wdata),
      .gen_rgnt_c (gen_rgnt_c),
      .ena_c      (ram_ena),
      .addra_c    (ram_addra),
      .enb_c      (ram_enb),
      .addrb_c    (ram_addrb),
      .dinb_c     (ram_dinb)
   );

endmodule

// File: tb/tb_ca_ram_sched.sv
// Directed self-checking bench for ca_ram_sched.
module tb_ca_ram_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic [10:0] counter_x, counter_y;
   logic        disp_req;
   logic [9:0]  disp_addr;
   logic        gen_start;
   logic        gen_rreq;
   logic [9:0]  gen_raddr;
   logic        gen_rgnt, gen_rvalid;
   logic        gen_wreq;
   logic [9:0]  gen_waddr;
   logic [15:0] gen_wdata;
   logic        gen_done;
   logic        init_start;
   logic        init_wreq;
   logic [9:0]  init_waddr;
   logic [15:0] init_wdata;
   logic        init_done;
   logic        ram_ena;
   logic [9:0]  ram_addra;
   logic        ram_enb;
   logic [9:0]  ram_addrb;
   logic [15:0] ram_dinb;
   logic        busy, overrun, timeout;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   ca_ram_sched dut (
      .clk        (clk),
      .rst        (rst),
      .counter_x  (counter_x),
      .counter_y  (counter_y),
      .disp_req   (disp_req),
      .disp_addr  (disp_addr),
      .gen_start  (gen_start),
      .gen_rreq   (gen_rreq),
      .gen_raddr  (gen_raddr),
      .gen_rgnt   (gen_rgnt),
      .gen_rvalid (gen_rvalid),
      .gen_wreq   (gen_wreq),
      .gen_waddr  (gen_waddr),
      .gen_wdata  (gen_wdata),
      .gen_done   (gen_done),
      .init_start (init_start),
      .init_wreq  (init_wreq),
      .init_waddr (init_waddr),
      .init_wdata (init_wdata),
      .init_done  (init_done),
      .ram_ena    (ram_ena),
      .ram_addra  (ram_addra),
      .ram_enb    (ram_enb),
      .ram_addrb  (ram_addrb),
      .ram_dinb   (ram_dinb),
      .busy       (busy),
      .overrun    (overrun),
      .timeout    (timeout)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   // Present the launch point for one edge; pulses are visible on return.
   task automatic launch(input logic [10:0] y);
      counter_y = y;
      counter_x = 11'd1296;
      tick();
      counter_x = 11'd0;
   endtask

   task automatic pulse_gen_done();
      gen_done = 1'b1;
      tick();
      gen_done = 1'b0;
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: got time-out expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; counter_x = '0; counter_y = '0;
      disp_req = 0; disp_addr = '0; gen_rreq = 0; gen_raddr = '0;
      gen_wreq = 0; gen_waddr = '0; gen_wdata = '0; gen_done = 0;
      init_wreq = 0; init_waddr = '0; init_wdata = '0; init_done = 0;
      tick(); tick();

      // Reset forcing and reset state
      disp_req = 1; gen_rreq = 1; init_wreq = 1; settle();
      chk("rst_ram_ena", ram_ena, 0);
      chk("rst_ram_enb", ram_enb, 0);
      chk("rst_gen_rgnt", gen_rgnt, 0);
      disp_req = 0; gen_rreq = 0; init_wreq = 0;
      chk("rst_busy", busy, 0);
      chk("rst_gen_start", gen_start, 0);
      chk("rst_init_start", init_start, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_gen_rvalid", gen_rvalid, 0);
      rst = 0; tick();

      // Generator line launch and completion
      counter_y = 11'd5; counter_x = 11'd1295; tick();
      chk("pre_launch_start", gen_start, 0);
      launch(11'd5);
      chk("gen_start_pulse", gen_start, 1);
      chk("gen_busy", busy, 1);
      chk("gen_no_init", init_start, 0);
      tick();
      chk("gen_start_once", gen_start, 0);
      repeat (38) tick();
      chk("gen_busy_hold", busy, 1);
      pulse_gen_done();
      chk("gen_done_idle", busy, 0);
      chk("gen_done_overrun", overrun, 0);
      chk("gen_done_timeout", timeout, 0);

      // Init line and write-port ownership
      launch(11'd1023);
      chk("init_start_pulse", init_start, 1);
      chk("init_no_gen", gen_start, 0);
      chk("init_busy", busy, 1);
      tick();
      chk("init_start_once", init_start, 0);
      init_wreq = 1; init_waddr = 10'h007; init_wdata = 16'hA5A5;
      gen_wreq = 1; gen_waddr = 10'h003; gen_wdata = 16'h1234; settle();
      chk("init_enb", ram_enb, 1);
      chk("init_addrb", ram_addrb, 32'h7);
      chk("init_dinb", ram_dinb, 32'hA5A5);
      init_wreq = 0; gen_rreq = 1; settle();
      chk("nonowner_enb", ram_enb, 0);
      chk("nonowner_addrb", ram_addrb, 0);
      chk("nonowner_dinb", ram_dinb, 0);
      chk("init_no_rgnt", gen_rgnt, 0);
      gen_wreq = 0; gen_rreq = 0;
      pulse_gen_done();
      chk("init_ignore_gen_done", busy, 1);
      init_done = 1; tick(); init_done = 0;
      chk("init_done_idle", busy, 0);
      init_done = 1; tick(); init_done = 0;
      chk("idle_done_ignored", busy, 0);

      // Lines past the init line do nothing
      launch(11'd1030);
      chk("past_last_gen", gen_start, 0);
      chk("past_last_init", init_start, 0);
      chk("past_last_busy", busy, 0);

      // Port A priority and read valid latency
      launch(11'd5);
      chk("arb_launch", busy, 1);
      tick();
      disp_req = 1; gen_rreq = 1; disp_addr = 10'h010; gen_raddr = 10'h020; settle();
      chk("arb_disp_addra", ram_addra, 32'h10);
      chk("arb_disp_rgnt", gen_rgnt, 0);
      chk("arb_disp_ena", ram_ena, 1);
      tick();
      chk("arb_rvalid_lo", gen_rvalid, 0);
      disp_req = 0; settle();
      chk("arb_gen_addra", ram_addra, 32'h20);
      chk("arb_gen_rgnt", gen_rgnt, 1);
      chk("arb_gen_ena", ram_ena, 1);
      tick();
      gen_rreq = 0;
      chk("arb_rvalid_hi", gen_rvalid, 1);
      tick();
      chk("arb_rvalid_drop", gen_rvalid, 0);
      gen_wreq = 1; gen_waddr = 10'h155; gen_wdata = 16'hBEEF; settle();
      chk("gen_enb", ram_enb, 1);
      chk("gen_addrb", ram_addrb, 32'h155);
      chk("gen_dinb", ram_dinb, 32'hBEEF);
      gen_wreq = 0;

      // Done in the launch cycle: treated as finished, new job proceeds
      gen_done = 1; launch(11'd7); gen_done = 0;
      chk("done_l_start", gen_start, 1);
      chk("done_l_busy", busy, 1);
      chk("done_l_overrun", overrun, 0);

      // Overrun while job active
      tick();
      launch(11'd8);
      chk("ovr_no_start", gen_start, 0);
      chk("ovr_flag", overrun, 1);
      chk("ovr_busy", busy, 1);
      pulse_gen_done();
      chk("ovr_idle", busy, 0);
      chk("ovr_sticky", overrun, 1);
      rst = 1; tick(); rst = 0;
      chk("ovr_rst_clear", overrun, 0);

      // Timeout abort after 511 active cycles
      launch(11'd5);
      repeat (510) tick();
      chk("to_busy_510", busy, 1);
      chk("to_flag_510", timeout, 0);
      tick();
      chk("to_idle_511", busy, 0);
      chk("to_flag_511", timeout, 1);
      launch(11'd9);
      chk("to_relaunch", gen_start, 1);
      chk("to_relaunch_busy", busy, 1);
      chk("to_sticky", timeout, 1);

      // Reset mid-job with an outstanding read request
      tick();
      gen_rreq = 1; settle();
      chk("mid_rgnt_pre", gen_rgnt, 1);
      rst = 1; settle();
      chk("mid_rst_ena", ram_ena, 0);
      chk("mid_rst_rgnt", gen_rgnt, 0);
      tick();
      rst = 0; gen_rreq = 0;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_timeout", timeout, 0);
      pulse_gen_done();
      chk("mid_late_done", busy, 0);
      chk("mid_late_start", gen_start, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ca_ram_sched.md
Name: ca_ram_sched

Overview:
Per-line scheduler and port arbiter for the shared 1K x 16 image RAM in the cellular-automaton VGA design. Issues one job per scan line, either a CA generation pass or the final-line init pass, from the sync generator's counters. Arbitrates RAM read port A between the display prefetcher, which has absolute priority, and the generator. Grants write port B only to the client owning the current job, and flags overruns and timeouts.

Parameters:
ADDR_W, 10, RAM address width
DATA_W, 16, RAM data width
START_X, 1296, counter_x value at which a line job is launched
LAST_Y, 1023, counter_y of the init line; lines below it run the generator
TIMEOUT, 511, maximum cycles a job may stay active before forced abort

Ports:
clk  in  1  pixel clock (same clock as sync generator)
rst  in  1  synchronous, active-high reset
counter_x  in  11  prefetch X counter
counter_y  in  11  Y counter
disp_req  in  1  display prefetch read request (never stalled)
disp_addr  in  ADDR_W  display read address
gen_start  out  1  one-cycle launch pulse to generator
gen_rreq  in  1  generator read request
gen_raddr  in  ADDR_W  generator read address
gen_rgnt  out  1  generator read granted this cycle
gen_rvalid  out  1  RAM douta holds generator data (gen_rgnt delayed 1)
gen_wreq  in  1  generator write request
gen_waddr  in  ADDR_W  generator write address
gen_wdata  in  DATA_W  generator write data
gen_done  in  1  generator finished job (pulse)
init_start  out  1  one-cycle launch pulse to init writer
init_wreq  in  1  init write request
init_waddr  in  ADDR_W  init write address
init_wdata  in  DATA_W  init write data
init_done  in  1  init finished job (pulse)
ram_ena  out  1  port A enable
ram_addra  out  ADDR_W  port A address
ram_enb  out  1  port B write enable
ram_addrb  out  ADDR_W  port B address
ram_dinb  out  DATA_W  port B data
busy  out  1  job active (state != IDLE)
overrun  out  1  sticky: launch point hit while job active
timeout  out  1  sticky: job aborted by TIMEOUT

Behaviour:
- Reset: state IDLE; gen_start, init_start, gen_rvalid, overrun, timeout all 0; job counter 0. While rst=1, ram_ena, ram_enb and gen_rgnt are forced to 0.
- Launch condition L is counter_x==START_X. It is evaluated each cycle; the start pulse is registered, high exactly 1 cycle after L.
  - L and counter_y<LAST_Y: gen_start.
  - L and counter_y==LAST_Y: init_start.
  - L and counter_y>LAST_Y: no action.
- FSM:
  - IDLE -> GEN on gen_start issue.
  - IDLE -> INIT on init_start issue.
  - GEN -> IDLE on gen_done.
  - INIT -> IDLE on init_done.
  - Any non-IDLE state -> IDLE when the job counter reaches TIMEOUT; timeout is set to 1.
- Job counter: cleared on entry to GEN/INIT, increments every active cycle, saturates.
- L while state != IDLE: no start pulse, overrun is set to 1 and the running job continues. A done pulse in the same cycle as L counts as finished: state goes IDLE and the new launch proceeds normally.
- done pulses received in IDLE, or from the non-owning client, are ignored.
- Port A (combinational mux, no added latency because the RAM is clocked on the phase-shifted clock):
  - ram_ena = disp_req | gen_rgnt.
  - ram_addra = disp_req ? disp_addr : gen_raddr.
  - gen_rgnt = gen_rreq & ~disp_req & (state==GEN).
  - gen_rvalid is the registered gen_rgnt. The generator must hold its request and address until granted.
- Port B:
  - ram_enb = (state==GEN & gen_wreq) | (state==INIT & init_wreq).
  - ram_addrb/ram_dinb come from the owning client and are 0 when ram_enb=0.
  - Writes from a non-owner are dropped silently.
- Same address read on A and written on B in the same cycle: no arbitration is applied; read-first RAM semantics are inherited from the RAM.
- Reset mid-job: returns to IDLE immediately with no done required. Sticky flags clear only on rst.

Decomposition:
- Shared package: state enum (IDLE, GEN, INIT), ADDR_W/DATA_W defaults, START_X/LAST_Y screen constants shared with the sync generator.
- One natural sub-module, ram_port_mux: the combinational port A/B muxing and grant logic, parameterised by widths. FSM, launch logic, counter and flags stay in ca_ram_sched.

Test Plan:
- counter_y=5, counter_x steps to 1296 -> gen_start=1 on the next cycle only, busy=1; gen_done 40 cycles later -> busy=0, flags stay 0.
- counter_y=1023 at x=1296 -> init_start pulse, never gen_start. init_wreq with waddr=0x07, wdata=0xA5A5 -> ram_enb=1, ram_addrb=0x07, ram_dinb=0xA5A5. gen_wreq in the same cycle is dropped.
- State GEN, disp_req=1 and gen_rreq=1 with disp_addr=0x10, gen_raddr=0x20 -> ram_addra=0x10, gen_rgnt=0. Next cycle disp_req=0 -> ram_addra=0x20, gen_rgnt=1, then gen_rvalid=1 one cycle later.
- Second L while still in GEN -> no start pulse, overrun=1 and stays 1 after a later gen_done; rst clears it.
- TIMEOUT=511 with gen_done never asserted -> state returns to IDLE after 511 active cycles, timeout=1; the next L launches normally.
- rst asserted mid-GEN with gen_rreq=1 -> ram_ena=0 and gen_rgnt=0 that cycle, busy=0 after; gen_done arriving afterwards is ignored.
